// File: rtl/pifo_pkg.sv
// pifo_pkg: default parameters, rank compare and the per-slot shifter select code
// shared by pifo_mport and pifo_match_sel.
package pifo_pkg;

    localparam int PIFO_NUMPIFO = 64;
    localparam int PIFO_NUMPUSH = 2;
    localparam int PIFO_BITPORT = 8;
    localparam int PIFO_BITPRIO = 16;
    localparam int PIFO_BITDATA = 32;
    localparam int PRIO_CMPW    = 32;

    typedef enum logic [3:0] {
        SEL_HOLD,
        SEL_SHIFT_UP,
        SEL_SHIFT_DOWN_1,
        SEL_SHIFT_DOWN_2,
        SEL_SHIFT_DOWN_3,
        SEL_SHIFT_DOWN_4,
        SEL_LOAD_0,
        SEL_LOAD_1,
        SEL_LOAD_2,
        SEL_LOAD_3
    } sel_e;

    // True when rank a is served no later than rank b; ranks are zero-extended to PRIO_CMPW.
    function automatic logic prio_le(input logic [PRIO_CMPW-1:0] a, input logic [PRIO_CMPW-1:0] b);
        return a <= b;
    endfunction

    function automatic sel_e sel_for_offset(input int off);
        case (off)
            -1:      return SEL_SHIFT_UP;
            1:       return SEL_SHIFT_DOWN_1;
            2:       return SEL_SHIFT_DOWN_2;
            3:       return SEL_SHIFT_DOWN_3;
            4:       return SEL_SHIFT_DOWN_4;
            default: return SEL_HOLD;
        endcase
    endfunction

    function automatic sel_e sel_for_load(input int k);
        case (k)
            0:       return SEL_LOAD_0;
            1:       return SEL_LOAD_1;
            2:       return SEL_LOAD_2;
            default: return SEL_LOAD_3;
        endcase
    endfunction

    function automatic logic sel_is_load(input sel_e s);
        return (s == SEL_LOAD_0) || (s == SEL_LOAD_1) || (s == SEL_LOAD_2) || (s == SEL_LOAD_3);
    endfunction

    function automatic int sel_load_idx(input sel_e s);
        case (s)
            SEL_LOAD_1: return 1;
            SEL_LOAD_2: return 2;
            SEL_LOAD_3: return 3;
            default:    return 0;
        endcase
    endfunction

    // Distance from the source slot to the destination slot (source = dest - offset).
    function automatic int sel_offset(input sel_e s);
        case (s)
            SEL_SHIFT_UP:     return -1;
            SEL_SHIFT_DOWN_1: return 1;
            SEL_SHIFT_DOWN_2: return 2;
            SEL_SHIFT_DOWN_3: return 3;
            SEL_SHIFT_DOWN_4: return 4;
            default:          return 0;
        endcase
    endfunction

endpackage

// File: rtl/pifo_match_sel.sv
// pifo_match_sel: first-match priority encoder; reports the lowest valid slot
// whose port tag equals key.
module pifo_match_sel
    import pifo_pkg::*;
#(
    parameter int NUMPIFO = PIFO_NUMPIFO,
    parameter int BITPORT = PIFO_BITPORT
) (
    input  logic [NUMPIFO-1:0]         vld,
    input  logic [NUMPIFO*BITPORT-1:0] ports,
    input  logic [BITPORT-1:0]         key,
    output logic                       hit,
    output logic [$clog2(NUMPIFO)-1:0] idx
);

    localparam int IDXW = $clog2(NUMPIFO);

    always_comb begin
        hit = 1'b0;
        idx = '0;
        // Scanning downward lets the lowest matching slot overwrite any higher one.
        for (int i = NUMPIFO - 1; i >= 0; i--) begin
            if (vld[i] && (ports[i*BITPORT +: BITPORT] == key)) begin
                hit = 1'b1;
                idx = IDXW'(i);
            end
        end
    end

endmodule

// File: rtl/pifo_mport.sv
// pifo_mport: multi-push, single-pop sorted queue (smallest rank first, FIFO on ties).
// Define PIFO_PORT_FILTER_EN to pop the best entry for port oprt instead of always slot 0.
module pifo_mport
    import pifo_pkg::*;
#(
    parameter int NUMPIFO = PIFO_NUMPIFO,
    parameter int NUMPUSH = PIFO_NUMPUSH,
    parameter int BITPORT = PIFO_BITPORT,
    parameter int BITPRIO = PIFO_BITPRIO,
    parameter int BITDATA = PIFO_BITDATA,
    parameter int PIFO_ID = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       pop,
    input  logic [BITPORT-1:0]         oprt,
    output logic                       ovld,
    output logic [BITPRIO-1:0]         opri,
    output logic [BITPORT-1:0]         oport,
    output logic [BITDATA-1:0]         odout,
    input  logic [NUMPUSH-1:0]         push,
    input  logic [NUMPUSH*BITPORT-1:0] uprt,
    input  logic [NUMPUSH*BITPRIO-1:0] upri,
    input  logic [NUMPUSH*BITDATA-1:0] udin,
    output logic [$clog2(NUMPIFO):0]   count,
    output logic                       full,
    output logic                       empty,
    output logic [NUMPUSH-1:0]         drop
);

    localparam int IDXW = $clog2(NUMPIFO);
    localparam int CNTW = IDXW + 1;
    localparam int unused_pifo_id = PIFO_ID;

    typedef struct packed {
        logic [BITPORT-1:0] port;
        logic [BITPRIO-1:0] prio;
        logic [BITDATA-1:0] data;
    } ent_t;

    function automatic logic rank_le(input logic [BITPRIO-1:0] a, input logic [BITPRIO-1:0] b);
        return prio_le(PRIO_CMPW'(a), PRIO_CMPW'(b));
    endfunction

    logic [NUMPIFO-1:0] vld_q, vld_d;
    ent_t               ent_q [NUMPIFO];
    ent_t               ent_d [NUMPIFO];
    sel_e               sel   [NUMPIFO];
    int                 shift [NUMPIFO];
    ent_t               push_ent [NUMPUSH];
    int                 pos      [NUMPUSH];
    logic [NUMPUSH-1:0] adm, drop_d, drop_q;
    int                 cap, adm_cnt;
    logic               match_hit, pop_hit;
    logic [IDXW-1:0]    pop_idx;
    logic [CNTW-1:0]    count_d, count_q;
    logic               full_d, full_q, empty_d, empty_q;
    logic               ovld_d, ovld_q;
    logic [BITPRIO-1:0] opri_d, opri_q;
    logic [BITPORT-1:0] oport_d, oport_q;
    logic [BITDATA-1:0] odout_d, odout_q;

`ifdef PIFO_PORT_FILTER_EN
    logic [NUMPIFO*BITPORT-1:0] port_flat;

    always_comb begin
        for (int i = 0; i < NUMPIFO; i++) port_flat[i*BITPORT +: BITPORT] = ent_q[i].port;
    end

    pifo_match_sel #(
        .NUMPIFO (NUMPIFO),
        .BITPORT (BITPORT)
    ) u_match (
        .vld   (vld_q),
        .ports (port_flat),
        .key   (oprt),
        .hit   (match_hit),
        .idx   (pop_idx)
    );
`else
    logic unused_oprt;
    assign unused_oprt = ^oprt;
    assign match_hit   = vld_q[0];
    assign pop_idx     = '0;
`endif

    assign pop_hit = pop && match_hit;

    // Capacity counts the slot freed by a same-cycle pop; pushes claim it in index order.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        adm     = '0;
        adm_cnt = 0;
        cap     = NUMPIFO - int'(count_q) + (pop_hit ? 1 : 0);
        for (int k = 0; k < NUMPUSH; k++) begin
            push_ent[k] = '{port: uprt[k*BITPORT +: BITPORT],
                            prio: upri[k*BITPRIO +: BITPRIO],
                            data: udin[k*BITDATA +: BITDATA]};
            if (push[k] && (adm_cnt < cap)) begin
                adm[k]  = 1'b1;
                adm_cnt = adm_cnt + 1;
            end
        end
        drop_d = push & ~adm;
    end

    // Final position of every surviving entry and every admitted push.
    always_comb begin
        for (int j = 0; j < NUMPIFO; j++) begin
            shift[j] = 0;
            for (int k = 0; k < NUMPUSH; k++) begin
                if (adm[k] && !rank_le(ent_q[j].prio, push_ent[k].prio)) shift[j] = shift[j] + 1;
            end
            if (pop_hit && (j > int'(pop_idx))) shift[j] = shift[j] - 1;
        end
        for (int k = 0; k < NUMPUSH; k++) begin
            pos[k] = 0;
            for (int j = 0; j < NUMPIFO; j++) begin
                if (vld_q[j] && rank_le(ent_q[j].prio, push_ent[k].prio)) pos[k] = pos[k] + 1;
            end
            if (pop_hit && rank_le(ent_q[pop_idx].prio, push_ent[k].prio)) pos[k] = pos[k] - 1;
            for (int m = 0; m < NUMPUSH; m++) begin
                if (adm[m] && (m < k) && rank_le(push_ent[m].prio, push_ent[k].prio)) pos[k] = pos[k] + 1;
                if (adm[m] && (m > k) && !rank_le(push_ent[k].prio, push_ent[m].prio)) pos[k] = pos[k] + 1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUMPIFO; i++) begin
            sel[i]   = SEL_HOLD;
            vld_d[i] = 1'b0;
            for (int k = 0; k < NUMPUSH; k++) begin
                if (adm[k] && (pos[k] == i)) begin
                    sel[i]   = sel_for_load(k);
                    vld_d[i] = 1'b1;
                end
            end
            for (int off = -1; off <= NUMPUSH; off++) begin
                if ((i - off >= 0) && (i - off < NUMPIFO)) begin
                    if (vld_q[i-off] && !(pop_hit && ((i - off) == int'(pop_idx))) && (shift[i-off] == off)) begin
                        sel[i]   = sel_for_offset(off);
                        vld_d[i] = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUMPIFO; i++) begin
            ent_d[i] = ent_q[i];
            if (sel_is_load(sel[i])) begin
                if (sel_load_idx(sel[i]) < NUMPUSH) ent_d[i] = push_ent[sel_load_idx(sel[i])];
            end else if ((i - sel_offset(sel[i]) >= 0) && (i - sel_offset(sel[i]) < NUMPIFO)) begin
                ent_d[i] = ent_q[i - sel_offset(sel[i])];
            end
        end
    end

    always_comb begin
        count_d = count_q + CNTW'(adm_cnt) - CNTW'(pop_hit);
        full_d  = (count_d == CNTW'(NUMPIFO));
        empty_d = (count_d == '0);
        ovld_d  = pop_hit;
        opri_d  = pop_hit ? ent_q[pop_idx].prio : opri_q;
        oport_d = pop_hit ? ent_q[pop_idx].port : oport_q;
        odout_d = pop_hit ? ent_q[pop_idx].data : odout_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q   <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            drop_q  <= '0;
            ovld_q  <= 1'b0;
            opri_q  <= '0;
            oport_q <= '0;
            odout_q <= '0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
            vld_q   <= vld_d;
            count_q <= count_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            drop_q  <= drop_d;
            ovld_q  <= ovld_d;
            opri_q  <= opri_d;
            oport_q <= oport_d;
            odout_q <= odout_d;
        end
    end

    // NOTE: vld_q alone decides whether a slot is occupied, so the payload array carries no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUMPIFO; i++) ent_q[i] <= ent_d[i];
    end

    assign ovld  = ovld_q;
    assign opri  = opri_q;
    assign oport = oport_q;
    assign odout = odout_q;
    assign count = count_q;
    assign full  = full_q;
    assign empty = empty_q;
    assign drop  = drop_q;

endmodule

// File: tb/tb_pifo_mport.sv
// tb_pifo_mport: directed and random stimulus against a sorted-queue reference model,
// with a per-cycle scoreboard checked by an independent monitor.
module tb_pifo_mport;

    localparam int N  = 16;
    localparam int NP = 2;
    localparam int BP = 8;
    localparam int BR = 16;
    localparam int BD = 32;
    localparam int CW = $clog2(N) + 1;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            pop = 1'b0;
    logic [BP-1:0]   oprt = '0;
    logic            ovld;
    logic [BR-1:0]   opri;
    logic [BP-1:0]   oport;
    logic [BD-1:0]   odout;
    logic [NP-1:0]   push = '0;
    logic [NP*BP-1:0] uprt = '0;
    logic [NP*BR-1:0] upri = '0;
    logic [NP*BD-1:0] udin = '0;
    logic [CW-1:0]   count;
    logic            full;
    logic            empty;
    logic [NP-1:0]   drop;

    pifo_mport #(
        .NUMPIFO (N),
        .NUMPUSH (NP),
        .BITPORT (BP),
        .BITPRIO (BR),
        .BITDATA (BD),
        .PIFO_ID (3)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .pop   (pop),
        .oprt  (oprt),
        .ovld  (ovld),
        .opri  (opri),
        .oport (oport),
        .odout (odout),
        .push  (push),
        .uprt  (uprt),
        .upri  (upri),
        .udin  (udin),
        .count (count),
        .full  (full),
        .empty (empty),
        .drop  (drop)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [BP-1:0] port;
        logic [BR-1:0] prio;
        logic [BD-1:0] data;
    } ent_t;

    typedef struct {
        logic          vld;
        logic [BR-1:0] prio;
        logic [BP-1:0] port;
        logic [BD-1:0] data;
        int            cnt;
        logic [NP-1:0] drop;
    } resp_t;

    ent_t          model[$];
    resp_t         sb[$];
    logic [BR-1:0] last_prio = '0;
    logic [BP-1:0] last_port = '0;
    logic [BD-1:0] last_data = '0;
    int            total = 0;
    int            bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus and queue the response the model predicts for it.
    task automatic cycle(input logic p, input logic [BP-1:0] o, input logic [NP-1:0] ps,
                         input logic [BP-1:0] t0, input logic [BR-1:0] r0, input logic [BD-1:0] d0,
                         input logic [BP-1:0] t1, input logic [BR-1:0] r1, input logic [BD-1:0] d1);
        resp_t r;
        ent_t  ins [NP];
        int    h;
        int    at;
        @(negedge clk);
        pop  = p;
        oprt = o;
        push = ps;
        uprt = {t1, t0};
        upri = {r1, r0};
        udin = {d1, d0};
        ins[0] = '{t0, r0, d0};
        ins[1] = '{t1, r1, d1};
        h = -1;
        if (p) begin
`ifdef PIFO_PORT_FILTER_EN
            for (int i = 0; i < model.size(); i++) if (h < 0 && model[i].port == o) h = i;
`else
            if (model.size() > 0) h = 0;
`endif
        end
        r.vld = (h >= 0);
        if (h >= 0) begin
            last_prio = model[h].prio;
            last_port = model[h].port;
            last_data = model[h].data;
            model.delete(h);
        end
        r.prio = last_prio;
        r.port = last_port;
        r.data = last_data;
        r.drop = '0;
        for (int k = 0; k < NP; k++) begin
            if (ps[k]) begin
                if (model.size() < N) begin
                    at = 0;
                    while (at < model.size() && model[at].prio <= ins[k].prio) at++;
                    model.insert(at, ins[k]);
                end else begin
                    r.drop[k] = 1'b1;
                end
            end
        end
        r.cnt = model.size();
        sb.push_back(r);
    endtask

    task automatic push1(input logic [BP-1:0] t, input logic [BR-1:0] r, input logic [BD-1:0] d);
        cycle(1'b0, '0, 2'b01, t, r, d, '0, '0, '0);
    endtask

    task automatic pop1(input logic [BP-1:0] o);
        cycle(1'b1, o, 2'b00, '0, '0, '0, '0, '0, '0);
    endtask

    task automatic idle();
        cycle(1'b0, '0, 2'b00, '0, '0, '0, '0, '0, '0);
    endtask

    task automatic drain();
        int guard = 0;
        while (model.size() > 0 && guard < 4 * N) begin
            pop1(model[0].port);
            guard++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        pop  = 1'b0;
        push = '0;
        rst  = 1'b0;
        #1;
        check("rst_count", count, 0);
        check("rst_ovld", ovld, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_drop", drop, 0);
        check("rst_opri", opri, 0);
        check("rst_oport", oport, 0);
        check("rst_odout", odout, 0);
        model.delete();
        last_prio = '0;
        last_port = '0;
        last_data = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        resp_t r;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                r = sb.pop_front();
                check("ovld", ovld, r.vld);
                check("opri", opri, r.prio);
                check("oport", oport, r.port);
                check("odout", odout, r.data);
                check("count", count, r.cnt);
                check("full", full, r.cnt == N);
                check("empty", empty, r.cnt == 0);
                check("drop", drop, r.drop);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        do_reset();

        // Sorted order from separate-cycle pushes.
        push1(0, 5, 32'h0000_0005);
        push1(0, 3, 32'h0000_0003);
        push1(0, 9, 32'h0000_0009);
        repeat (3) pop1(0);
        idle();

        // Same-cycle tie goes to the lower push index; later equal ranks stay FIFO.
        cycle(1'b0, '0, 2'b11, 0, 4, 32'hAAAA_0000, 0, 4, 32'hBBBB_0000);
        pop1(0);
        pop1(0);
        push1(0, 7, 32'hC0C0_0001);
        push1(0, 7, 32'hD0D0_0002);
        pop1(0);
        pop1(0);

        // Port filter: match, then a port with no entry.
        cycle(1'b0, '0, 2'b11, 1, 2, 32'h1111_0002, 2, 1, 32'h2222_0001);
        pop1(1);
        pop1(3);
        idle();
        drain();

        // Fill, then a two-port push alongside a hitting pop leaves room for one.
        for (int c = 0; c < N / 2; c++)
            cycle(1'b0, '0, 2'b11, 0, BR'($urandom_range(0, 7)), $urandom, 0, BR'($urandom_range(0, 7)), $urandom);
        cycle(1'b1, 0, 2'b11, 0, 3, 32'hF00D_0000, 0, 2, 32'hF00D_0001);
        idle();
        drain();

        // Random push and pop every cycle.
        for (int c = 0; c < 1000; c++)
            cycle(1'b1, BP'($urandom_range(0, 3)), NP'($urandom_range(0, 3)),
                  BP'($urandom_range(0, 3)), BR'($urandom_range(0, 7)), $urandom,
                  BP'($urandom_range(0, 3)), BR'($urandom_range(0, 7)), $urandom);

        // Reset mid-burst with ten entries and a pop result on the outputs.
        do_reset();
        for (int c = 0; c < 5; c++)
            cycle(1'b0, '0, 2'b11, 0, BR'($urandom_range(0, 7)), $urandom, 1, BR'($urandom_range(0, 7)), $urandom);
        cycle(1'b1, model[0].port, 2'b01, 1, 6, 32'h5A5A_5A5A, '0, '0, '0);
        do_reset();
        pop1(0);
        idle();

        @(posedge clk);
        #2;
        check("sb_left", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pifo_mport.md
# pifo_mport

Parametrised push-in-first-out queue: a NUMPUSH-push-port, single-pop-port successor to the two-push `pifo`. Entries stay sorted by priority (smallest first, FIFO among equal priorities) in a shift-register array of NUMPIFO slots. Pops can select the best entry for one egress port rather than only the global head. Sits between the classifier/rank stage and the egress arbiter, with one instance per scheduling node, identified by PIFO_ID.

## Interface
- NUMPIFO, 64, entry slots (≥2)
- NUMPUSH, 2, push ports (1–4)
- BITPORT, 8, egress-port tag width
- BITPRIO, 16, rank width; smaller = served earlier
- BITDATA, 32, payload width
- PIFO_ID, 0, instance tag, no functional effect
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous assert, active-low; deassertion synchronous to clk upstream
- pop  in  1  pop request
- oprt  in  BITPORT  pop port filter
- ovld  out  1  pop result valid
- opri  out  BITPRIO  popped rank
- oport  out  BITPORT  popped entry port tag
- odout  out  BITDATA  popped payload
- push  in  NUMPUSH  push strobe per port
- uprt  in  NUMPUSH*BITPORT  port tags, port i at [i*BITPORT +: BITPORT]
- upri  in  NUMPUSH*BITPRIO  ranks, same packing
- udin  in  NUMPUSH*BITDATA  payloads, same packing
- count  out  $clog2(NUMPIFO)+1  occupied slots
- full  out  1  count == NUMPIFO
- empty  out  1  count == 0
- drop  out  NUMPUSH  per-port push rejected, one-cycle pulse

## Operation
- Array slots 0..NUMPIFO-1 hold {valid, port, prio, data}. Valid entries are contiguous from slot 0 and ordered by ascending prio.
- Ordering key: (prio, arrival). A new entry is inserted after every existing entry with prio ≤ its prio. Same-cycle pushes are ordered among themselves by prio, with the lower push index first on ties.
- Pop selects the lowest-index valid slot with port == oprt. The selected slot is removed and the tail shifts up one. No match or empty: nothing is removed.
- Pop sees only the pre-cycle contents. Pushes in the same cycle can never be popped in that cycle.
- Admission capacity per cycle = NUMPIFO − count + (pop hit ? 1 : 0).
- Pushes are admitted in ascending index order up to that capacity. The rest are dropped, and their drop bits pulse on the next cycle.
- count_next = count + admitted − (pop hit). The arithmetic is in the BITPIFO+1-bit width, and count never exceeds NUMPIFO.
- Reset: every slot invalid, count=0, empty=1, full=0, ovld=0, opri/oport/odout=0, drop=0. Reset asserted mid-operation discards all contents immediately.

## Timing
- Pop latency 1: a pop in cycle N gives ovld/opri/oport/odout in cycle N+1. ovld is high for exactly one cycle per hit. The data outputs hold their last value when ovld=0.
- Push-to-visible latency 1: an entry pushed in cycle N can be popped in cycle N+1.
- count/full/empty/drop are registered and reflect cycle N effects in cycle N+1.
- No backpressure handshake. Upstream must watch full/count; drop is the only rejection indication.
- Pop and all NUMPUSH pushes may be active in the same cycle.

## Configuration
- PIFO_PORT_FILTER_EN defined: pop matching uses oprt as described above.
- PIFO_PORT_FILTER_EN undefined: oprt is ignored and pop always takes slot 0 when it is valid. The port compare logic is removed; oport still reports the stored tag.

## Structure
- pifo_pkg: default parameter constants, a function comparing rank (prio ≤) for the insert decision, and a typedef for the shifter select code (HOLD, SHIFT_UP, SHIFT_DOWN_k, LOAD_k).
- Array typedefs stay local, because their widths are module parameters.
- Sub-module pifo_match_sel: NUMPIFO-wide first-match priority encoder returning hit and index. It is parametrised on NUMPIFO and BITPORT and reused for filtered pop.

## Test plan
- Reset, then push prio 5,3,9 on port 0 in three cycles, then pop×3 with oprt=0 → outputs prio 3,5,9, each one cycle after its pop; empty=1 afterwards.
- Same-cycle push: port0 prio 4 data A, port1 prio 4 data B, then pop twice → A then B (tie goes to lower index); pushes in later cycles with equal prio come out FIFO.
- Filter: entries (port 1, prio 2), (port 2, prio 1); pop with oprt=1 → prio 2 returned, the port-2 entry stays; pop with oprt=3 → ovld=0 next cycle, count unchanged.
- Fill to NUMPIFO, then push on both ports with pop hit in the same cycle → port 0 admitted, drop=2'b10, count stays NUMPIFO.
- Push and pop every cycle for 1000 random cycles, checked against a reference model → output order and count match.
- Assert rst low mid-burst with count=10 → count=0, ovld=0 immediately; the first pop after release gives ovld=0.
